// File: rtl/pose_pkg.sv
// Shared types and saturation helpers for the pose frame-sync stage.
package pose_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UPD  = 2'd1,
    TICK = 2'd2
  } pose_state_e;

  // Clamp v into the unsigned range [0, 2^w-1].
  function automatic int sat_u(input int v, input int w);
    int hi;
    int r;
    hi = (1 << w) - 1;
    r  = v;
    if (v < 0) r = 0;
    else if (v > hi) r = hi;
    return r;
  endfunction

  // Clamp v into the signed w-bit range.
  function automatic int sat_s(input int v, input int w);
    int hi;
    int lo;
    int r;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    r  = v;
    if (v < lo) r = lo;
    else if (v > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/pose_axis_filter.sv
// One axis of the conditioning path: offset, saturate, then exponential smoothing
// toward the saturated raw value (or direct load when bypassed).
module pose_axis_filter
  import pose_pkg::*;
#(
  parameter int W         = 12,
  parameter int OW        = 13,
  parameter bit IS_SIGNED = 1'b0,
  parameter int SHIFT     = 2
) (
  input  logic [W-1:0]  sample,
  input  logic [OW-1:0] offset,
  input  logic [W-1:0]  cur,
  input  logic          bypass,
  output logic [W-1:0]  result
);

  localparam int EXT_W  = 32 - W;
  localparam int EXT_OW = 32 - OW;

  int s_val;
  int o_val;
  int c_val;
  int raw;
  int sat;
  int diff;
  int filt;

  // All arithmetic is done at 32 bits, which covers the width+2 raw sum and
  // the width+1 signed difference without overflow.
  always_comb begin
    s_val  = int'({{EXT_W{IS_SIGNED & sample[W-1]}}, sample});
    c_val  = int'({{EXT_W{IS_SIGNED & cur[W-1]}}, cur});
    o_val  = int'({{EXT_OW{offset[OW-1]}}, offset});
    raw    = s_val + o_val;
    sat    = IS_SIGNED ? sat_s(raw, W) : sat_u(raw, W);
    diff   = sat - c_val;
    filt   = c_val + (diff >>> SHIFT);
    result = bypass ? W'(sat) : W'(filt);
  end

endmodule

// File: rtl/pose_frame_sync.sv
// Buffers the latest camera sample per channel and, once per frame, walks the
// channels applying offset, saturation, smoothing, lost-track timeout and override.
module pose_frame_sync
  import pose_pkg::*;
#(
  parameter int NUM_CH       = 3,
  parameter int XY_W         = 12,
  parameter int Z_W          = 14,
  parameter int SMOOTH_SHIFT = 2,
  parameter int LOST_FRAMES  = 8
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         vsync_in,
  input  logic [NUM_CH-1:0]            cam_valid_in,
  input  logic [NUM_CH*XY_W-1:0]       cam_x_in,
  input  logic [NUM_CH*XY_W-1:0]       cam_y_in,
  input  logic [NUM_CH*Z_W-1:0]        cam_z_in,
  input  logic [NUM_CH*(XY_W+1)-1:0]   off_x_in,
  input  logic [NUM_CH*(XY_W+1)-1:0]   off_y_in,
  input  logic [NUM_CH*Z_W-1:0]        off_z_in,
  input  logic [NUM_CH-1:0]            ovr_mask_in,
  input  logic [XY_W-1:0]              ovr_x_in,
  input  logic [XY_W-1:0]              ovr_y_in,
  input  logic [Z_W-1:0]               ovr_z_in,
  output logic [NUM_CH*XY_W-1:0]       pose_x_out,
  output logic [NUM_CH*XY_W-1:0]       pose_y_out,
  output logic [NUM_CH*Z_W-1:0]        pose_z_out,
  output logic [NUM_CH-1:0]            pose_valid_out,
  output logic                         frame_tick_out,
  output pose_state_e                  fsm_state_out
);

  localparam int         CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int         OXY_W    = XY_W + 1;
  localparam logic [7:0] LOST_MAX = 8'(LOST_FRAMES);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  pose_state_e       state;
  logic [CH_W-1:0]   ch;
  logic              pend;
  logic              vsync_q;
  logic              frame_edge;
  logic              tick_q;
  logic [NUM_CH-1:0] fresh;
  logic [NUM_CH-1:0] valid_q;

  logic [XY_W-1:0] sh_x  [NUM_CH];
  logic [XY_W-1:0] sh_y  [NUM_CH];
  logic [Z_W-1:0]  sh_z  [NUM_CH];
  logic [XY_W-1:0] out_x [NUM_CH];
  logic [XY_W-1:0] out_y [NUM_CH];
  logic [Z_W-1:0]  out_z [NUM_CH];
  logic [7:0]      lost  [NUM_CH];

  logic [XY_W-1:0] nx_x;
  logic [XY_W-1:0] nx_y;
  logic [Z_W-1:0]  nx_z;
  logic            bypass;

  assign frame_edge = vsync_in & ~vsync_q;
  assign bypass     = (lost[ch] == LOST_MAX);

  // One shared filter per axis; the channel under walk is muxed in by ch.
  pose_axis_filter #(.W(XY_W), .OW(OXY_W), .IS_SIGNED(1'b0), .SHIFT(SMOOTH_SHIFT)) u_filt_x (
    .sample (sh_x[ch]),
    .offset (off_x_in[ch*OXY_W +: OXY_W]),
    .cur    (out_x[ch]),
    .bypass (bypass),
    .result (nx_x)
  );

  pose_axis_filter #(.W(XY_W), .OW(OXY_W), .IS_SIGNED(1'b0), .SHIFT(SMOOTH_SHIFT)) u_filt_y (
    .sample (sh_y[ch]),
    .offset (off_y_in[ch*OXY_W +: OXY_W]),
    .cur    (out_y[ch]),
    .bypass (bypass),
    .result (nx_y)
  );

  pose_axis_filter #(.W(Z_W), .OW(Z_W), .IS_SIGNED(1'b1), .SHIFT(SMOOTH_SHIFT)) u_filt_z (
    .sample (sh_z[ch]),
    .offset (off_z_in[ch*Z_W +: Z_W]),
    .cur    (out_z[ch]),
    .bypass (bypass),
    .result (nx_z)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state   <= IDLE;
      ch      <= '0;
      pend    <= 1'b0;
      vsync_q <= 1'b0;
      tick_q  <= 1'b0;
      fresh   <= '0;
      valid_q <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        sh_x[k]  <= '0;
        sh_y[k]  <= '0;
        sh_z[k]  <= '0;
        out_x[k] <= '0;
        out_y[k] <= '0;
        out_z[k] <= '0;
        lost[k]  <= LOST_MAX;
      end
    end else begin
      vsync_q <= vsync_in;
      tick_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_edge || pend) begin
            state <= UPD;
            ch    <= '0;
            pend  <= 1'b0;
          end
        end
        UPD: begin
          if (frame_edge) pend <= 1'b1;
          if (ovr_mask_in[ch]) begin
            out_x[ch]   <= ovr_x_in;
            out_y[ch]   <= ovr_y_in;
            out_z[ch]   <= ovr_z_in;
            valid_q[ch] <= 1'b1;
            lost[ch]    <= '0;
          end else if (fresh[ch]) begin
            out_x[ch]   <= nx_x;
            out_y[ch]   <= nx_y;
            out_z[ch]   <= nx_z;
            valid_q[ch] <= 1'b1;
            lost[ch]    <= '0;
            fresh[ch]   <= 1'b0;
          end else begin
            if (lost[ch] != LOST_MAX) lost[ch] <= lost[ch] + 8'd1;
            if (lost[ch] >= LOST_MAX - 8'd1) valid_q[ch] <= 1'b0;
          end
          if (ch == LAST_CH) begin
            state  <= TICK;
            tick_q <= 1'b1;
          end else begin
            ch <= ch + 1'b1;
          end
        end
        TICK: begin
          if (frame_edge || pend) begin
            state <= UPD;
            ch    <= '0;
            pend  <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // Placed after the walk so a same-cycle strobe keeps fresh set.
      for (int k = 0; k < NUM_CH; k++) begin
        if (cam_valid_in[k]) begin
          sh_x[k]  <= cam_x_in[k*XY_W +: XY_W];
          sh_y[k]  <= cam_y_in[k*XY_W +: XY_W];
          sh_z[k]  <= cam_z_in[k*Z_W +: Z_W];
          fresh[k] <= 1'b1;
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_pack
    assign pose_x_out[k*XY_W +: XY_W] = out_x[k];
    assign pose_y_out[k*XY_W +: XY_W] = out_y[k];
    assign pose_z_out[k*Z_W +: Z_W]   = out_z[k];
  end

  assign pose_valid_out = valid_q;
  assign frame_tick_out = tick_q;
  assign fsm_state_out  = state;

endmodule
